dma_periph_requester: RTL

Peripheral-side endpoint of one DMA channel handshake: the device that raises DREQ, waits for DACK, and serves the controller's IOR_N/IOW_N strobes. It sits between a local data source/sink and the DMA controller bus. It buffers words in a small FIFO and requests service in single or demand mode. It also flags terminal count (EOP_N) and overrun/underrun.

---
 rtl/dma_periph_requester_pkg.sv | 27 ++
 rtl/dma_periph_requester_if.sv | 30 +++
 rtl/dma_periph_requester_fifo.sv | 55 +++++
 rtl/dma_periph_requester.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_periph_requester_pkg.sv
// Shared types and default sizing for the DMA peripheral requester.
// Contents: FSM state enum, transfer direction and request mode enums,
// default DEPTH / DATA_W / THRESH constants.
package dma_pkg;

   localparam int unsigned DEF_DEPTH  = 8;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_THRESH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   // Device-to-memory is served by IOR_N, memory-to-device by IOW_N.
   typedef enum logic {
      DIR_DEV2MEM = 1'b0,
      DIR_MEM2DEV = 1'b1
   } dir_e;

   typedef enum logic {
      MODE_SINGLE = 1'b0,
      MODE_DEMAND = 1'b1
   } mode_e;

endpackage : dma_pkg

// File: rtl/dma_periph_requester_if.sv
// DMA controller bus seen by one peripheral channel.
// Signals: dreq (request, registered), dack (acknowledge), ior_n / iow_n
// (active-low I/O strobes), eop_n (active-low terminal count), db_in (bus
// data for IOW), db_out_c / db_oe_c (combinational bus data and drive enable
// for IOR).
// Modports: master = DMA controller side, slave = peripheral side.
interface dma_periph_requester_if #(
   parameter int unsigned DATA_W = 8
) ();

   logic              dreq;
   logic              dack;
   logic              ior_n;
   logic              iow_n;
   logic              eop_n;
   logic [DATA_W-1:0] db_in;
   logic [DATA_W-1:0] db_out_c;
   logic              db_oe_c;

   modport master (
      input  dreq, db_out_c, db_oe_c,
      output dack, ior_n, iow_n, eop_n, db_in
   );

   modport slave (
      output dreq, db_out_c, db_oe_c,
      input  dack, ior_n, iow_n, eop_n, db_in
   );

endinterface : dma_periph_requester_if

// File: rtl/dma_periph_requester_fifo.sv
// Synchronous FIFO buffering words between the local port and the DMA bus.
// Ports: clk_i, rst_ni (async active-low), push_i/wdata_i (write side),
// pop_i/head_c_o (read side, head word visible combinationally),
// full_c_o, empty_c_o, count_c_o (occupancy, 0..DEPTH).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dma_periph_fifo #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [DATA_W-1:0]      wdata_i,
   input  logic                   pop_i,
   output logic [DATA_W-1:0]      head_c_o,
   output logic                   full_c_o,
   output logic                   empty_c_o,
   output logic [$clog2(DEPTH):0] count_c_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [CW-1:0]     wr_ptr_q;
   logic [CW-1:0]     rd_ptr_q;
   logic              push_ok;
   logic              pop_ok;

   assign count_c_o = wr_ptr_q - rd_ptr_q;
   assign full_c_o  = (count_c_o == CW'(DEPTH));
   assign empty_c_o = (wr_ptr_q == rd_ptr_q);
   assign head_c_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign push_ok   = push_i && !full_c_o;
   assign pop_ok    = pop_i && !empty_c_o;

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

   // Read/write pointers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + CW'(push_ok);
         rd_ptr_q <= rd_ptr_q + CW'(pop_ok);
      end
   end

endmodule : dma_periph_fifo

// File: rtl/dma_periph_requester.sv
// Peripheral endpoint of one DMA channel: raises DREQ, waits for DACK and
// serves IOR_N / IOW_N strobes from / into a local FIFO.
// Ports: clk_i, reset_n_i (async active-low); dir_i / mode_i (latched in
// IDLE); bus (DMA controller interface, slave side); wr_valid_i/wr_data_i/
// wr_ready_c_o (local push, device-to-memory); rd_valid_c_o/rd_data_c_o/
// rd_ready_i (local pop, memory-to-device); tc_flag_o / err_flag_o (sticky,
// cleared by flag_clr_i); count_c_o (FIFO occupancy).
module dma_periph_requester
   import dma_pkg::*;
#(
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned THRESH = DEF_THRESH
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    dir_i,
   input  logic                    mode_i,
   dma_periph_requester_if.slave   bus,
   input  logic                    wr_valid_i,
   input  logic [DATA_W-1:0]       wr_data_i,
   output logic                    wr_ready_c_o,
   output logic                    rd_valid_c_o,
   output logic [DATA_W-1:0]       rd_data_c_o,
   input  logic                    rd_ready_i,
   output logic                    tc_flag_o,
   output logic                    err_flag_o,
   input  logic                    flag_clr_i,
   output logic [$clog2(DEPTH):0]  count_c_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e            state_q, state_d;
   dir_e              dir_q, dir_d, dir_eff;
   mode_e             mode_q, mode_d, mode_eff;
   logic              dreq_q, dreq_d;
   logic              eop_q, eop_d;        // terminal count seen this transfer
   logic              done_q, done_d;      // a strobe completed this transfer
   logic              stb_low_q, stb_low_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              tc_q, tc_d;
   logic              err_q, err_d;

   logic              in_ack;
   logic              stb_n;
   logic              stb_done;
   logic              tc_set;
   logic              err_set;
   logic              bus_pop, bus_push;
   logic              loc_pop, loc_push;
   logic              fifo_push, fifo_pop;
   logic [DATA_W-1:0] fifo_wdata;
   logic [DATA_W-1:0] head;
   logic              full, empty;
   logic [CW-1:0]     count;
   logic [CW-1:0]     cnt_nxt;
   logic [CW-1:0]     level;
   logic              req_cond;
   logic              demand_more;

   dma_periph_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (reset_n_i),
      .push_i    (fifo_push),
      .wdata_i   (fifo_wdata),
      .pop_i     (fifo_pop),
      .head_c_o  (head),
      .full_c_o  (full),
      .empty_c_o (empty),
      .count_c_o (count)
   );

   // In IDLE the live direction/mode apply; afterwards the latched copies.
   assign dir_eff  = (state_q == ST_IDLE) ? dir_e'(dir_i)  : dir_q;
   assign mode_eff = (state_q == ST_IDLE) ? mode_e'(mode_i) : mode_q;

   // Strobe tracking: a strobe completes on the first high sample after low.
   assign in_ack   = (state_q == ST_ACK);
   assign stb_n    = (dir_q == DIR_MEM2DEV) ? bus.iow_n : bus.ior_n;
   assign stb_done = in_ack && bus.dack && stb_low_q && stb_n;
   assign tc_set   = bus.dack && !bus.eop_n && (state_q != ST_IDLE);

   // Bus side transfers and error detection.
   assign bus_pop  = stb_done && (dir_q == DIR_DEV2MEM) && !empty;
   assign bus_push = stb_done && (dir_q == DIR_MEM2DEV) && !full;
   assign err_set  = stb_done && (((dir_q == DIR_DEV2MEM) && empty) ||
                                  ((dir_q == DIR_MEM2DEV) && full));

   // Local port handshakes.
   assign wr_ready_c_o = (dir_eff == DIR_DEV2MEM) && !full;
   assign rd_valid_c_o = (dir_eff == DIR_MEM2DEV) && !empty;
   assign rd_data_c_o  = rd_valid_c_o ? head : '0;
   assign loc_push     = wr_valid_i && wr_ready_c_o;
   assign loc_pop      = rd_ready_i && rd_valid_c_o;

   assign fifo_push  = loc_push || bus_push;
   assign fifo_pop   = loc_pop || bus_pop;
   assign fifo_wdata = bus_push ? wdata_q : wr_data_i;
   assign cnt_nxt    = count + CW'(fifo_push) - CW'(fifo_pop);
   assign count_c_o  = count;

   // Request conditions: words available (DEV2MEM) or space free (MEM2DEV).
   assign level       = (dir_eff == DIR_DEV2MEM) ? count : (CW'(DEPTH) - count);
   assign req_cond    = (mode_eff == MODE_SINGLE) ? (level != '0)
                                                  : (level >= CW'(THRESH));
   assign demand_more = (dir_q == DIR_DEV2MEM) ? (cnt_nxt != '0)
                                               : (cnt_nxt != CW'(DEPTH));

   // Bus read data is driven combinationally while IOR_N is low in ACK.
   assign bus.db_oe_c  = in_ack && bus.dack && (dir_q == DIR_DEV2MEM) && !bus.ior_n;
   assign bus.db_out_c = (bus.db_oe_c && !empty) ? head : '0;
   assign bus.dreq     = dreq_q;
   assign tc_flag_o    = tc_q;
   assign err_flag_o   = err_q;

   // Next-state and register-input logic.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      mode_d    = mode_q;
      dreq_d    = dreq_q;
      eop_d     = eop_q;
      done_d    = done_q;
      stb_low_d = 1'b0;
      wdata_d   = wdata_q;
      tc_d      = tc_q;
      err_d     = err_q;

      // Set beats clear when both happen in one cycle.
      if (flag_clr_i) begin
         tc_d  = 1'b0;
         err_d = 1'b0;
      end
      if (tc_set) begin
         tc_d = 1'b1;
      end
      if (err_set) begin
         err_d = 1'b1;
      end

      // DACK low aborts any strobe in flight.
      if (in_ack && bus.dack) begin
         stb_low_d = !stb_n;
         if ((dir_q == DIR_MEM2DEV) && !bus.iow_n) begin
            wdata_d = bus.db_in;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            dir_d  = dir_e'(dir_i);
            mode_d = mode_e'(mode_i);
            eop_d  = 1'b0;
            done_d = 1'b0;
            dreq_d = 1'b0;
            if (req_cond) begin
               state_d = ST_REQ;
               dreq_d  = 1'b1;
            end
         end
         ST_REQ: begin
            dreq_d = 1'b1;
            if (bus.dack) begin
               state_d = ST_ACK;
               if (tc_set) begin
                  eop_d  = 1'b1;
                  dreq_d = 1'b0;
               end
            end
         end
         ST_ACK: begin
            if (!bus.dack) begin
               state_d = ST_IDLE;
               dreq_d  = 1'b0;
            end else begin
               if (tc_set) begin
                  eop_d = 1'b1;
               end
               if (stb_done) begin
                  done_d = 1'b1;
               end
               if (tc_set || eop_q) begin
                  dreq_d = 1'b0;
               end else if (mode_q == MODE_SINGLE) begin
                  dreq_d = !(done_q || stb_done);
               end else begin
                  dreq_d = demand_more;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            dreq_d  = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_IDLE;
         dir_q     <= DIR_DEV2MEM;
         mode_q    <= MODE_SINGLE;
         dreq_q    <= 1'b0;
         eop_q     <= 1'b0;
         done_q    <= 1'b0;
         stb_low_q <= 1'b0;
         wdata_q   <= '0;
         tc_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         mode_q    <= mode_d;
         dreq_q    <= dreq_d;
         eop_q     <= eop_d;
         done_q    <= done_d;
         stb_low_q <= stb_low_d;
         wdata_q   <= wdata_d;
         tc_q      <= tc_d;
         err_q     <= err_d;
      end
   end

endmodule : dma_periph_requester
